serial_adder: RTL



---
 rtl/serial_adder.sv | 109 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    count;

  logic load;
  logic shift;
  logic last;
  logic fa_s;
  logic fa_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (count == CW'(WIDTH - 1)) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control decode and the shared full-adder cell
  always_comb begin
    load  = start && ((state == IDLE) || (state == DONE));
    shift = (state == RUN);
    last  = shift && (count == CW'(WIDTH - 1));
    fa_s  = a_sh[0] ^ b_sh[0] ^ carry;
    fa_c  = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      count <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      busy <= (state_nx == RUN);
      done <= (state_nx == DONE);
      if (load) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        count <= '0;
      end else if (shift) begin
        a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
        sum   <= {fa_s, sum[WIDTH-1:1]};
        carry <= fa_c;
        if (last) begin
          cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          // carry into the MSB is the flop value on the final bit
          ovf  <= carry ^ fa_c;
`endif
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule
